// File: rtl/piso_ctrl_pkg.sv
// Shared encodings for the PISO transmit arbiter.
// FRAME_LEN grows by one parity bit when PISO_PARITY_EN is defined.
package piso_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

`ifdef PISO_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_len(input int data_w);
    return data_w + PARITY_BITS;
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Load/shift-right register, LSB first, updating on the falling clock edge.
module piso_shift_core #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              dout
);

  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;

  // Next value: a load takes priority over a shift.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift) begin
      shreg_d = shreg_q >> 1;
    end else begin
      shreg_d = shreg_q;
    end
  end

  // Shift register state.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= {DATA_W{1'b0}};
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign dout = shreg_q[0];

endmodule

// File: rtl/piso_tx_arbiter.sv
// Two-requester round-robin scheduler feeding one LSB-first serialiser.
// Optional build macro PISO_PARITY_EN appends an even-parity bit to each frame.
module piso_tx_arbiter
  import piso_ctrl_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid0,
  input  logic [DATA_W-1:0] in_data0,
  output logic              in_ready0,
  input  logic              in_valid1,
  input  logic [DATA_W-1:0] in_data1,
  output logic              in_ready1,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              frame_last,
  output logic              src_id,
  output logic              busy
);

  localparam int FRAME_LEN = frame_len(DATA_W);
  localparam int CW        = $clog2(FRAME_LEN + 1);
  localparam int GW        = ($clog2(GAP_CYCLES + 1) > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : {GW{1'b0}};

  state_e          state_q, state_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic            src_id_q, src_id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            ser_out_q, ser_out_d;
  logic            ser_valid_q, ser_valid_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_last_q, frame_last_d;
  logic            grant_s, accept_s, shift_s, core_dout_s, bit_s;
  logic [DATA_W-1:0] data_sel_s;

`ifdef PISO_PARITY_EN
  logic parity_q, parity_d;

  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

  assign bit_s = (cnt_q == CW'(DATA_W)) ? parity_q : core_dout_s;
`else
  assign bit_s = core_dout_s;
`endif

  // Round-robin pointer only breaks ties; a lone requester always wins.
  assign grant_s    = (in_valid0 & in_valid1) ? rr_ptr_q : in_valid1;
  assign accept_s   = (state_q == ST_IDLE) & (in_valid0 | in_valid1);
  assign data_sel_s = grant_s ? in_data1 : in_data0;
  assign shift_s    = (state_q == ST_SHIFT);

  assign in_ready0 = accept_s & ~reset & (grant_s == SRC0);
  assign in_ready1 = accept_s & ~reset & (grant_s == SRC1);

  piso_shift_core #(.DATA_W(DATA_W)) u_shift_core (
    .clk   (clk),
    .reset (reset),
    .load  (accept_s),
    .shift (shift_s),
    .din   (data_sel_s),
    .dout  (core_dout_s)
  );

  // Next-state, counters and framing outputs.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    src_id_d      = src_id_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    ser_out_d     = 1'b0;
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_last_d  = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d      = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          src_id_d = grant_s;
          rr_ptr_d = ~grant_s;
          cnt_d    = {CW{1'b0}};
          state_d  = ST_SHIFT;
`ifdef PISO_PARITY_EN
          parity_d = even_parity(data_sel_s);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        ser_out_d     = bit_s;
        ser_valid_d   = 1'b1;
        frame_start_d = (cnt_q == {CW{1'b0}});
        frame_last_d  = (cnt_q == LAST_CNT);
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          gap_d   = {GW{1'b0}};
          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = {GW{1'b0}};
          state_d = ST_IDLE;
        end else begin
          gap_d   = gap_q + 1'b1;
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any frame in flight.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= SRC0;
      src_id_q      <= SRC0;
      cnt_q         <= {CW{1'b0}};
      gap_q         <= {GW{1'b0}};
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      src_id_q      <= src_id_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      frame_last_q  <= frame_last_d;
`ifdef PISO_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign frame_last  = frame_last_q;
  assign src_id      = src_id_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
